// File: rtl/mips_mem_loader_pkg.sv
// mips_loader_pkg: shared constants and types for the MIPS program loader / memory dumper
package mips_loader_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int WORD_BYTES = 4;
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP_REQ, DUMP_CAP, DUMP_OUT} loader_state_t;
    typedef logic [DEF_WIDTH-1:0] word_t;
endpackage

// File: rtl/mips_mem_loader_if.sv
// mips_mem_loader_if: load stream, dump stream and core memory ports; checksum_out exists with MIPS_LOADER_CHECKSUM_EN
interface mips_mem_loader_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16,
    parameter int RUN_W = 24
);
    logic             load_start_in;
    logic [WIDTH-1:0] load_base_in;
    logic [CNT_W-1:0] load_count_in;
    logic             word_valid_in;
    logic [WIDTH-1:0] word_in;
    logic             word_ready_out;
    logic [RUN_W-1:0] run_cycles_in;
    logic             dump_start_in;
    logic [WIDTH-1:0] dump_base_in;
    logic [CNT_W-1:0] dump_count_in;
    logic             dump_valid_out;
    logic [WIDTH-1:0] dump_data_out;
    logic             dump_ready_in;
    logic             cpu_reset_out;
    logic             instrWrite_out;
    logic [WIDTH-1:0] instr_address_out;
    logic [WIDTH-1:0] instr_out;
    logic [WIDTH-1:0] read_data_address_out;
    logic [WIDTH-1:0] read_data_in;
    logic             busy_out;
    logic             done_out;
`ifdef MIPS_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_out;
`endif
    modport master (
`ifdef MIPS_LOADER_CHECKSUM_EN
        output checksum_out,
`endif
        input  load_start_in, load_base_in, load_count_in, word_valid_in, word_in,
        input  run_cycles_in, dump_start_in, dump_base_in, dump_count_in, dump_ready_in, read_data_in,
        output word_ready_out, dump_valid_out, dump_data_out, cpu_reset_out, instrWrite_out,
        output instr_address_out, instr_out, read_data_address_out, busy_out, done_out
    );
    modport slave (
`ifdef MIPS_LOADER_CHECKSUM_EN
        input  checksum_out,
`endif
        output load_start_in, load_base_in, load_count_in, word_valid_in, word_in,
        output run_cycles_in, dump_start_in, dump_base_in, dump_count_in, dump_ready_in, read_data_in,
        input  word_ready_out, dump_valid_out, dump_data_out, cpu_reset_out, instrWrite_out,
        input  instr_address_out, instr_out, read_data_address_out, busy_out, done_out
    );
endinterface

// File: rtl/mips_mem_loader_addr_gen.sv
// mips_loader_addr_gen: byte-address counter producing base + WORD_BYTES*index, wrapping modulo 2^WIDTH
module mips_loader_addr_gen
    import mips_loader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_base,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_addr
);
    logic [WIDTH-1:0] r_addr;
    always_ff @(posedge clk) begin
        if (rst) r_addr <= '0;
        else if (i_load) r_addr <= i_base;
        else if (i_inc) r_addr <= r_addr + WIDTH'(WORD_BYTES);
    end
    assign o_addr = r_addr;
endmodule

// File: rtl/mips_mem_loader.sv
// mips_mem_loader: loads instruction words into the core, runs it, then dumps data memory; MIPS_LOADER_CHECKSUM_EN adds checksum_out
module mips_mem_loader
    import mips_loader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 16,
    parameter int RUN_W = 24
) (
    input logic clock,
    input logic reset_in,
    mips_mem_loader_if.master bus
);
    localparam logic [2:0] S_IDLE = IDLE;
    localparam logic [2:0] S_LOAD = LOAD;
    localparam logic [2:0] S_RUN = RUN;
    localparam logic [2:0] S_DUMP_REQ = DUMP_REQ;
    localparam logic [2:0] S_DUMP_CAP = DUMP_CAP;
    localparam logic [2:0] S_DUMP_OUT = DUMP_OUT;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_load_cnt, r_load_i, r_dump_cnt, r_dump_j;
    logic [RUN_W-1:0] r_run_cycles, r_run_cnt;
    logic             r_wr, r_dump_valid, r_done;
    logic [WIDTH-1:0] r_instr, r_instr_addr, r_dump_data;
    logic             w_ready, w_accept, w_load_start, w_expire, w_dump_go, w_dump_hs, w_dump_last;
    logic [WIDTH-1:0] w_load_addr, w_dump_addr;

    assign w_ready = r_state == S_LOAD && r_load_i != r_load_cnt;
    assign w_accept = w_ready && bus.word_valid_in;
    assign w_load_start = r_state == S_IDLE && bus.load_start_in;
    assign w_expire = r_run_cycles != '0 && r_run_cnt + RUN_W'(1) == r_run_cycles;
    assign w_dump_go = r_state == S_RUN && (bus.dump_start_in || w_expire);
    assign w_dump_hs = r_state == S_DUMP_OUT && bus.dump_ready_in;
    assign w_dump_last = r_dump_j + CNT_W'(1) == r_dump_cnt;

    mips_loader_addr_gen #(.WIDTH(WIDTH)) u_load_addr (
        .clk(clock), .rst(reset_in), .i_load(w_load_start), .i_base(bus.load_base_in),
        .i_inc(w_accept), .o_addr(w_load_addr)
    );
    mips_loader_addr_gen #(.WIDTH(WIDTH)) u_dump_addr (
        .clk(clock), .rst(reset_in), .i_load(w_dump_go), .i_base(bus.dump_base_in),
        .i_inc(w_dump_hs), .o_addr(w_dump_addr)
    );

    // LOAD lingers one cycle after the last accept so the final write lands while the core is still held
    always_ff @(posedge clock) begin
        if (reset_in) begin
            r_state <= S_IDLE;
            r_load_cnt <= '0;
            r_load_i <= '0;
            r_dump_cnt <= '0;
            r_dump_j <= '0;
            r_run_cycles <= '0;
            r_run_cnt <= '0;
            r_wr <= 1'b0;
            r_dump_valid <= 1'b0;
            r_done <= 1'b0;
            r_instr <= '0;
            r_instr_addr <= '0;
            r_dump_data <= '0;
        end else begin
            r_wr <= w_accept;
            r_done <= 1'b0;
            r_run_cnt <= r_state == S_RUN ? r_run_cnt + RUN_W'(1) : '0;
            if (w_accept) begin
                r_instr <= bus.word_in;
                r_instr_addr <= w_load_addr;
                r_load_i <= r_load_i + CNT_W'(1);
            end
            case (r_state)
                S_IDLE: if (bus.load_start_in) begin
                    r_load_cnt <= bus.load_count_in;
                    r_load_i <= '0;
                    r_run_cycles <= bus.run_cycles_in;
                    r_state <= bus.load_count_in == '0 ? S_RUN : S_LOAD;
                end
                S_LOAD: if (r_load_i == r_load_cnt) r_state <= S_RUN;
                S_RUN: if (w_dump_go) begin
                    r_dump_cnt <= bus.dump_count_in;
                    r_dump_j <= '0;
                    r_state <= bus.dump_count_in == '0 ? S_IDLE : S_DUMP_REQ;
                    r_done <= bus.dump_count_in == '0;
                end
                S_DUMP_REQ: r_state <= S_DUMP_CAP;
                S_DUMP_CAP: begin
                    r_dump_data <= bus.read_data_in;
                    r_dump_valid <= 1'b1;
                    r_state <= S_DUMP_OUT;
                end
                S_DUMP_OUT: if (bus.dump_ready_in) begin
                    r_dump_valid <= 1'b0;
                    r_dump_j <= r_dump_j + CNT_W'(1);
                    r_state <= w_dump_last ? S_IDLE : S_DUMP_REQ;
                    r_done <= w_dump_last;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MIPS_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] r_sum;
    always_ff @(posedge clock) begin
        if (reset_in || w_load_start) r_sum <= '0;
        else if (w_accept) r_sum <= r_sum + bus.word_in;
    end
    assign bus.checksum_out = r_sum;
`endif

    assign bus.word_ready_out = w_ready;
    assign bus.cpu_reset_out = r_state != S_RUN;
    assign bus.instrWrite_out = r_wr;
    assign bus.instr_address_out = r_instr_addr;
    assign bus.instr_out = r_instr;
    assign bus.read_data_address_out = w_dump_addr;
    assign bus.dump_valid_out = r_dump_valid;
    assign bus.dump_data_out = r_dump_data;
    assign bus.busy_out = r_state != S_IDLE;
    assign bus.done_out = r_done;
endmodule

// File: doc/mips_mem_loader.md
Name: mips_mem_loader

Overview:
- Hardware-side program loader and memory dumper for the single-cycle MIPS core.
- Accepts a stream of instruction words and writes them into instruction memory, holding the CPU in reset while it does so.
- Releases the CPU to run, then on request reads back a window of data memory as an output stream.
- Drives the same instruction-write and data-read ports the core exposes for program loading and result inspection.

Parameters:
- WIDTH, 32, data/address word width in bits.
- CNT_W, 16, width of word-count inputs.
- RUN_W, 24, width of run-cycle counter.

Ports:
- clock  in  1  system clock.
- reset_in  in  1  synchronous, active-high reset.
- load_start_in  in  1  pulse; begins a load session (accepted in IDLE only).
- load_base_in  in  WIDTH  byte address of first instruction word.
- load_count_in  in  CNT_W  number of words to load.
- word_valid_in  in  1  input word valid.
- word_in  in  WIDTH  instruction word.
- word_ready_out  out  1  loader accepts word this cycle.
- run_cycles_in  in  RUN_W  CPU run length after load, in cycles. 0 means run until dump_start_in.
- dump_start_in  in  1  pulse; ends RUN and begins dump. Ignored outside RUN.
- dump_base_in  in  WIDTH  byte address of first data word.
- dump_count_in  in  CNT_W  words to dump.
- dump_valid_out  out  1  dump word valid.
- dump_data_out  out  WIDTH  dumped data word.
- dump_ready_in  in  1  consumer accepts dump word.
- cpu_reset_out  out  1  reset to core.
- instrWrite_out  out  1  instruction-memory write enable.
- instr_address_out  out  WIDTH  instruction write byte address.
- instr_out  out  WIDTH  instruction write data.
- read_data_address_out  out  WIDTH  data-memory read byte address.
- read_data_in  in  WIDTH  data-memory read data; valid the cycle after address is driven.
- busy_out  out  1  high in any state except IDLE.
- done_out  out  1  one-cycle pulse when dump completes.

Behaviour:
- One clock. Reset is synchronous, active-high, on reset_in.
- Reset values:
  - state IDLE.
  - cpu_reset_out=1.
  - All other outputs 0.
  - Counters 0.
- State IDLE:
  - cpu_reset_out=1, word_ready_out=0.
  - load_start_in latches load_base_in, load_count_in and run_cycles_in.
  - Goes to LOAD, or directly to RUN if load_count_in==0.
- State LOAD:
  - cpu_reset_out=1, word_ready_out=1.
  - On each word_valid_in&&word_ready_out, the write is registered with 1-cycle latency: next cycle instrWrite_out=1, instr_out=word, instr_address_out=base+4*i.
  - Address arithmetic is modulo 2^WIDTH; wrap is silent.
  - After the last word is accepted, word_ready_out drops in the same cycle via combinational count check. The final write still issues, then the state goes to RUN.
  - instrWrite_out is never high outside the cycle following an accepted word.
- State RUN:
  - cpu_reset_out=0.
  - The run counter increments each cycle.
  - Leaves RUN when the counter reaches run_cycles_in (nonzero), or on dump_start_in.
  - If both occur in the same cycle, dump_start_in wins and its base/count are latched.
  - On counter expiry, dump uses dump_base_in/dump_count_in sampled in that cycle.
  - Goes to DUMP_REQ, or to IDLE with done_out pulse if count==0.
- State DUMP_REQ:
  - cpu_reset_out=1 (freezes the core; memories keep their contents).
  - Drives read_data_address_out=base+4*j, then goes to DUMP_CAP.
- State DUMP_CAP:
  - Captures read_data_in into the output register and asserts dump_valid_out, then goes to DUMP_OUT.
- State DUMP_OUT:
  - Holds dump_valid_out and dump_data_out stable until dump_ready_in.
  - On handshake: j++. If j==count, go to IDLE and pulse done_out. Otherwise go to DUMP_REQ.
  - Throughput is 1 word per 3 cycles minimum.
- load_start_in and dump_start_in are ignored in any state where they are not listed.
- reset_in mid-operation:
  - Aborts immediately to IDLE.
  - Any pending write is dropped (instrWrite_out=0 next cycle).
  - dump_valid_out=0.

Optional Feature:
- Macro MIPS_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum_out [WIDTH].
  - checksum_out is the running modulo-2^WIDTH sum of all words accepted in LOAD.
  - Cleared on reset_in and on load_start_in acceptance.
  - Stable from RUN onward.
- When undefined: the port and adder are absent; behaviour is otherwise identical.

Decomposition:
- Package mips_loader_pkg holds:
  - WIDTH default.
  - WORD_BYTES=4.
  - Typedef enum loader_state_t {IDLE, LOAD, RUN, DUMP_REQ, DUMP_CAP, DUMP_OUT}.
  - Typedef word_t.
- One natural sub-module: mips_loader_addr_gen, a base+4*index address counter with load/increment/clear. Instantiated twice, once for load and once for dump.

Test Plan:
- Reset, then load_base=0x0, count=3, words 0x20080005/0x20090007/0x01095020 -> three instrWrite_out pulses at addresses 0x0/0x4/0x8; cpu_reset_out=1 throughout; then RUN with cpu_reset_out=0.
- Load with word_valid_in toggling every other cycle -> no writes in gaps; addresses strictly consecutive; word_ready_out=0 after 3rd word.
- run_cycles=10, dump_base=0x10, count=2, memory[0x10]=0xA, [0x14]=0xB -> cpu_reset_out falls for exactly 10 cycles; dump emits 0xA then 0xB; done_out pulses once.
- dump_ready_in held low 5 cycles on first dump word -> dump_valid_out and dump_data_out stable; no new read address issued until handshake.
- run_cycles=0 with dump_start_in issued in cycle 20 of RUN, and reset_in asserted mid-dump -> RUN ends on dump_start_in; after reset: IDLE, cpu_reset_out=1, dump_valid_out=0, busy_out=0.
- With MIPS_LOADER_CHECKSUM_EN, load 0xFFFFFFFF,0x2 -> checksum_out=0x00000001.
